// File: rtl/add_pipelined.sv
`default_nettype none
// ============================================================================
// Module  : add_pipelined
// Brief   : N-bit adder/subtractor split into STAGES chunks with the carry
//           registered between chunks; valid/ready stream with global stall.
// Rev     : 1.0  initial release
// ============================================================================
module add_pipelined #(
    parameter int N      = 32,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] ina,
    input  logic [N-1:0] inb,
    input  logic         ci,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out,
    output logic         co,
    output logic         ovf
);

    localparam int c_cw   = N / STAGES;
    localparam int c_last = STAGES - 1;

    if ((STAGES < 1) || (STAGES > N)) begin : g_bad_stages
        $error("add_pipelined: STAGES must lie in 1..N");
    end
    if ((N % STAGES) != 0) begin : g_bad_split
        $error("add_pipelined: N must be a multiple of STAGES");
    end

    logic              w_adv;
    logic [N-1:0]      w_beff;
    logic              w_cin;
    logic              w_ovf;
    logic [STAGES-1:0] w_vin;
    logic [STAGES-1:0] w_cin_stg;
    logic [STAGES-1:0] w_co;
    logic [c_cw-1:0]   w_sum [STAGES];

    // Per-stage view of the beat as chunks: operand chunks above the stage,
    // finished sum chunks below it.
    logic [c_cw-1:0]   w_ain [STAGES][STAGES];
    logic [c_cw-1:0]   w_bin [STAGES][STAGES];
    logic [c_cw-1:0]   w_sin [STAGES][STAGES];

    logic [c_cw-1:0]   r_a   [STAGES][STAGES];
    logic [c_cw-1:0]   r_b   [STAGES][STAGES];
    logic [c_cw-1:0]   r_s   [STAGES][STAGES];
    logic [STAGES-1:0] r_v;
    logic [STAGES-1:0] r_c;
    logic              r_ovf;

    assign w_adv    = out_ready | ~r_v[c_last];
    assign in_ready = w_adv;
    assign w_beff   = sub ? ~inb : inb;
    assign w_cin    = sub ? ~ci  : ci;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign w_vin[0]     = in_valid;
            assign w_cin_stg[0] = w_cin;
            for (genvar j = 0; j < STAGES; j++) begin : g_chunk
                assign w_ain[0][j] = ina[j*c_cw +: c_cw];
                assign w_bin[0][j] = w_beff[j*c_cw +: c_cw];
                assign w_sin[0][j] = '0;
            end
        end else begin : g_body
            assign w_vin[k]     = r_v[k-1];
            assign w_cin_stg[k] = r_c[k-1];
            for (genvar j = 0; j < STAGES; j++) begin : g_chunk
                assign w_ain[k][j] = r_a[k-1][j];
                assign w_bin[k][j] = r_b[k-1][j];
                assign w_sin[k][j] = r_s[k-1][j];
            end
        end
        assign {w_co[k], w_sum[k]} = {1'b0, w_ain[k][k]} + {1'b0, w_bin[k][k]}
                                   + {{c_cw{1'b0}}, w_cin_stg[k]};
    end

    // Sign bits of the top chunk are still visible at the last stage.
    assign w_ovf = (w_ain[c_last][c_last][c_cw-1] == w_bin[c_last][c_last][c_cw-1])
                && (w_sum[c_last][c_cw-1] != w_ain[c_last][c_last][c_cw-1]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v   <= '0;
            r_c   <= '0;
            r_ovf <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                for (int j = 0; j < STAGES; j++) begin
                    r_a[k][j] <= '0;
                    r_b[k][j] <= '0;
                    r_s[k][j] <= '0;
                end
            end
        end else if (w_adv) begin
            r_v   <= w_vin;
            r_c   <= w_co;
            r_ovf <= w_ovf;
            for (int k = 0; k < STAGES; k++) begin
                for (int j = 0; j < STAGES; j++) begin
                    if (j < k) begin
                        r_s[k][j] <= w_sin[k][j];
                    end else if (j == k) begin
                        r_s[k][j] <= w_sum[k];
                    end else begin
                        r_a[k][j] <= w_ain[k][j];
                        r_b[k][j] <= w_bin[k][j];
                    end
                end
            end
        end
    end

    for (genvar j = 0; j < STAGES; j++) begin : g_out
        assign out[j*c_cw +: c_cw] = r_s[c_last][j];
    end

    assign out_valid = r_v[c_last];
    assign co        = r_c[c_last];
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_add_pipelined.sv
`default_nettype none
// ============================================================================
// Module  : tb_add_pipelined
// Brief   : directed and scoreboarded checks of add_pipelined (32/4) plus an
//           N=8 sweep over STAGES 1,2,4,8.
// Rev     : 1.0  initial release
// ============================================================================
module tb_add_pipelined;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] ina, inb, out;
    logic        ci, sub, co, ovf;

    always #5 clk = ~clk;

    add_pipelined #(.N(32), .STAGES(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ina(ina), .inb(inb), .ci(ci), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .co(co), .ovf(ovf)
    );

    logic       s_valid, s_ci, s_sub;
    logic [7:0] s_a, s_b;
    logic       s_ready [4];
    logic       s_ovalid[4];
    logic       s_co    [4];
    logic       s_ovf   [4];
    logic [7:0] s_out   [4];

    for (genvar g = 0; g < 4; g++) begin : g_sweep
        add_pipelined #(.N(8), .STAGES(1 << g)) u_sw (
            .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(s_ready[g]),
            .ina(s_a), .inb(s_b), .ci(s_ci), .sub(s_sub),
            .out_valid(s_ovalid[g]), .out_ready(1'b1),
            .out(s_out[g]), .co(s_co[g]), .ovf(s_ovf[g])
        );
    end

    int          total = 0;
    int          bad   = 0;
    int          run, maxrun, nout;
    int          s_nout[4];
    bit          acc;
    logic [33:0] q[$];
    logic [9:0]  sq[4][$];
    logic [31:0] pats[4];

    function automatic logic [33:0] model32(input logic [31:0] a, input logic [31:0] b,
                                            input logic c, input logic s);
        logic [31:0] be;
        logic [32:0] r;
        be = s ? ~b : b;
        r  = {1'b0, a} + {1'b0, be} + {32'd0, (s ? ~c : c)};
        return {((a[31] == be[31]) && (r[31] != a[31])), r};
    endfunction

    function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b,
                                          input logic c, input logic s);
        logic [7:0] be;
        logic [8:0] r;
        be = s ? ~b : b;
        r  = {1'b0, a} + {1'b0, be} + {8'd0, (s ? ~c : c)};
        return {((a[7] == be[7]) && (r[7] != a[7])), r};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: record transfers on the falling edge, return #1 after the rising edge.
    task automatic tick();
        logic [33:0] e;
        logic [9:0]  e8;
        @(negedge clk);
        acc = in_valid && in_ready;
        if (acc) q.push_back(model32(ina, inb, ci, sub));
        run = out_valid ? run + 1 : 0;
        if (run > maxrun) maxrun = run;
        if (out_valid && out_ready) begin
            nout++;
            check("beat_expected", 64'(q.size() > 0), 64'd1);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("beat", {30'd0, ovf, co, out}, {30'd0, e});
            end
        end
        for (int g = 0; g < 4; g++) begin
            if (s_valid && s_ready[g]) sq[g].push_back(model8(s_a, s_b, s_ci, s_sub));
            if (s_ovalid[g]) begin
                s_nout[g]++;
                check("sweep_expected", 64'(sq[g].size() > 0), 64'd1);
                if (sq[g].size() > 0) begin
                    e8 = sq[g].pop_front();
                    check("sweep_beat", {54'd0, s_ovf[g], s_co[g], s_out[g]}, {54'd0, e8});
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic one(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic c, input logic s,
                       input logic [31:0] eo, input logic ec, input logic ev);
        int n;
        ina = a; inb = b; ci = c; sub = s; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'd3);
        check(tag, {30'd0, ovf, co, out}, {30'd0, ev, ec, eo});
        tick();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out"},   64'(out),       64'd0);
        check({tag, "_co"},    64'(co),        64'd0);
        check({tag, "_ovf"},   64'(ovf),       64'd0);
        check({tag, "_ready"}, 64'(in_ready),  64'd1);
    endtask

    initial begin
        int sent, cyc, idx, base;
        logic [31:0] held;
        bit have;

        pats = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h5555_5555, 32'hAAAA_AAAA};
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        ina = '0; inb = '0; ci = 1'b0; sub = 1'b0;
        s_valid = 1'b0; s_a = '0; s_b = '0; s_ci = 1'b0; s_sub = 1'b0;
        run = 0; maxrun = 0; nout = 0;
        for (int g = 0; g < 4; g++) s_nout[g] = 0;
        #1 rst = 1'b0;
        #12;
        check_idle("reset");
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) tick();
        check_idle("idle");

        // Exact latency of a single beat.
        ina = 32'hFFFF_FFFF; inb = 32'h0; ci = 1'b1; sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("lat_e0", 64'(out_valid), 64'd0);
        tick(); check("lat_e1", 64'(out_valid), 64'd0);
        tick(); check("lat_e2", 64'(out_valid), 64'd0);
        tick(); check("lat_e3", 64'(out_valid), 64'd1);
        check("lat_result", {30'd0, ovf, co, out}, {30'd0, 1'b0, 1'b1, 32'h0});
        tick();

        // Back-to-back pattern combos.
        run = 0; maxrun = 0;
        for (int i = 0; i < 32; i++) begin
            ina = pats[i / 8]; inb = pats[(i / 2) % 4]; ci = i[0]; sub = 1'b0;
            in_valid = 1'b1;
            tick();
            check("b2b_accept", 64'(acc), 64'd1);
        end
        in_valid = 1'b0;
        repeat (8) tick();
        check("b2b_rate", 64'(maxrun), 64'd32);
        check("b2b_drained", 64'(q.size()), 64'd0);

        one("aa55c", 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        one("sub5m7", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        one("submin", 32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        one("addmax", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        one("subbrw", 32'h10, 32'd3, 1'b1, 1'b1, 32'h0000_000C, 1'b1, 1'b0);
        one("sub0m1", 32'h0, 32'd1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);

        // Backpressure: fill the pipe, stall five cycles, release.
        out_ready = 1'b0; idx = 0; cyc = 0; base = nout;
        while (idx < 4 && cyc < 20) begin
            ina = 32'h0101_0101 * (idx + 1); inb = 32'h1000_0001; ci = idx[0]; sub = idx[1];
            in_valid = 1'b1;
            tick();
            if (acc) idx++;
            cyc++;
        end
        check("bp_filled", 64'(idx), 64'd4);
        held = out;
        ina = 32'h0101_0101 * (idx + 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_hold", 64'(out), 64'(held));
        end
        out_ready = 1'b1; cyc = 0;
        while (idx < 8 && cyc < 20) begin
            ina = 32'h0101_0101 * (idx + 1); inb = 32'h1000_0001; ci = idx[0]; sub = idx[1];
            in_valid = 1'b1;
            tick();
            if (acc) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        repeat (8) tick();
        check("bp_count", 64'(nout - base), 64'd8);
        check("bp_drained", 64'(q.size()), 64'd0);

        // Random valid/ready traffic.
        sent = 0; cyc = 0; have = 1'b0;
        while (sent < 10000 && cyc < 40000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!have && $urandom_range(0, 3) != 0) begin
                have = 1'b1;
                ina = $urandom; inb = $urandom; ci = 1'($urandom); sub = 1'($urandom);
            end
            in_valid = have;
            if (!have) begin
                ina = 'x; inb = 'x;
            end
            tick();
            if (acc) begin
                have = 1'b0;
                sent++;
            end
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (8) tick();
        check("rand_sent", 64'(sent), 64'd10000);
        check("rand_drained", 64'(q.size()), 64'd0);

        // Reset with the pipe full.
        out_ready = 1'b0; idx = 0; cyc = 0;
        while (idx < 4 && cyc < 20) begin
            ina = 32'h1234_0000 + idx; inb = 32'h0000_4321; ci = 1'b0; sub = 1'b0;
            in_valid = 1'b1;
            tick();
            if (acc) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        check("rst_full", 64'(out_valid), 64'd1);
        #2 rst = 1'b0;
        #1;
        check_idle("rst_mid");
        q.delete();
        out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        base = nout;
        repeat (8) tick();
        check("rst_none", 64'(nout - base), 64'd0);
        one("post_rst", 32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, 32'h0000_0004, 1'b0, 1'b0);

        // N=8 sweep: all ina, 64 inb upper values, random low bits, ci, sub.
        for (int v = 0; v < 16384; v++) begin
            s_a = v[7:0];
            s_b = {v[13:8], 2'($urandom)};
            s_ci = 1'($urandom); s_sub = 1'($urandom);
            s_valid = 1'b1;
            tick();
        end
        s_valid = 1'b0;
        repeat (12) tick();
        for (int g = 0; g < 4; g++) begin
            check("sweep_count", 64'(s_nout[g]), 64'd16384);
            check("sweep_drained", 64'(sq[g].size()), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
